raizing_extratext_ram: RTL and testbench
========================================

// Module: raizing_extratext_ram
// PURPOSE
//  CPU-side owner of the extra-text memories: text VRAM (4K x16), line-select RAM (256 x16) and
//  line-scroll RAM (256 x16). Accepts 68000-style bus cycles, with strobes arriving from the CPU clock domain.
//  Writes the three RAMs with byte enables and returns DTACK.
//  Serves the extra-text renderer's read ports at fixed 1-cycle latency.
//  Zero-fills all three RAMs after reset.
// PARAMETERS
//  VRAM_AW    12  text VRAM word-address width (4096 words)
//  LINE_AW    8   select/scroll RAM word-address width (256 words)
//  CLR_VALUE  16'h0000  fill value written by the post-reset clear engine
// PORTS
//  CLK96            in   1   96 MHz system clock
//  RESET96          in   1   reset, asynchronous, active-high
//  CPU_ADDR         in   12  CPU word address within the selected region (A12..A1)
//  CPU_DIN          in   16  CPU write data
//  CPU_DOUT         out  16  CPU read data, valid while CPU_DTACK_N=0
//  CPU_RW           in   1   1=read, 0=write
//  CPU_UDS_N        in   1   upper data strobe, async to CLK96
//  CPU_LDS_N        in   1   lower data strobe, async to CLK96
//  CPU_CS_VRAM      in   1   chip select, text VRAM region
//  CPU_CS_SELECT    in   1   chip select, line-select region
//  CPU_CS_SCROLL    in   1   chip select, line-scroll region
//  CPU_DTACK_N      out  1   data acknowledge, active-low
//  CLEAR_BUSY       out  1   high while the post-reset fill runs
//  TEXTVRAM_ADDR    in   12  renderer read address
//  TEXTVRAM_DATA    out  16  renderer read data
//  TEXTSELECT_ADDR  in   8   renderer read address
//  TEXTSELECT_DATA  out  16  renderer read data
//  TEXTSCROLL_ADDR  in   8   renderer read address
//  TEXTSCROLL_DATA  out  16  renderer read data
// BEHAVIOUR
//  - Reset values:
//    - CPU_DTACK_N=1, CPU_DOUT=0, CLEAR_BUSY=1.
//    - All renderer data outputs=0; FSM=CLEAR; clear counter=0.
//  - Strobe synchronisation:
//    - UDS_N and LDS_N each pass through a 2-FF synchroniser. "strb" = either synced strobe low.
//    - CS, RW, ADDR and DIN are sampled only in IDLE, when strb is first seen, and held until ACK ends.
//  - FSM CLEAR:
//    - One word written per cycle to all three RAMs at counter address. The counter runs 0..4095.
//    - Select/scroll RAMs are written only while counter<256.
//    - Counter reaches 4095: go to IDLE, CLEAR_BUSY=0. Total 4096 cycles.
//    - CPU strobes are ignored during CLEAR; DTACK_N stays 1, so the CPU waits.
//  - FSM IDLE:
//    - Go to ACCESS when strb=1 and any CS=1. Otherwise stay.
//    - CS priority when several are asserted: VRAM > SELECT > SCROLL.
//  - FSM ACCESS, one cycle:
//    - Write: byte lanes [15:8] written if UDS, [7:0] if LDS.
//    - Read: issue the RAM read. Go to RDWAIT.
//    - Select/scroll regions use CPU_ADDR[7:0]; upper bits are ignored (aliasing).
//  - FSM RDWAIT, one cycle:
//    - Capture RAM data into CPU_DOUT. For writes, CPU_DOUT is unchanged. Go to ACK.
//  - FSM ACK:
//    - DTACK_N=0 until strb deasserts, then DTACK_N=1 and go to IDLE.
//    - DTACK_N falls exactly 3 CLK96 cycles after the cycle in which strb is first seen.
//  - Abort: strb drops while in ACCESS or RDWAIT.
//    - A started write still completes.
//    - Go directly to IDLE without asserting DTACK.
//  - Renderer ports:
//    - Registered, read-only, never stalled.
//    - Data is valid on the clock edge after the address is presented (1-cycle latency).
//    - Same-address collision with a CPU write or clear returns the OLD word (read-before-write).
//  - Reset mid-cycle: FSM to CLEAR, DTACK_N=1 immediately (async); the RAMs are refilled.
// CONFIGURATION
//  RAIZING_EXTRATEXT_RDBACK_EN defined:
//    - CPU reads return RAM contents via a second read port per RAM.
//  RAIZING_EXTRATEXT_RDBACK_EN undefined:
//    - No CPU read port is built.
//    - CPU reads return 16'hFFFF. Timing and ACK sequence are identical.
// TESTING
//  - Reset, then wait 4096 cycles:
//    - CLEAR_BUSY falls at cycle 4096.
//    - Renderer reads of VRAM[0], VRAM[4095], SELECT[255] and SCROLL[255] return 16'h0000.
//  - CPU write VRAM addr 12'h123 data 16'hABCD with UDS only:
//    - Renderer reads 12'h123 -> 16'hAB00.
//    - DTACK_N low 3 cycles after strb is seen, high after strobe release.
//  - Write SCROLL 12'h105 = 16'h0040:
//    - TEXTSCROLL_ADDR=8'h05 -> 16'h0040 (alias check).
//  - Read select 8'h10 holding 16'h1234:
//    - With _EN: CPU_DOUT=16'h1234.
//    - Without _EN: CPU_DOUT=16'hFFFF.
//    - Both at DTACK_N low.
//  - Renderer reads VRAM 12'h010 in the same cycle a CPU write of 16'h5555 lands there (old 16'h0000):
//    - Read data is 16'h0000; the next read returns 16'h5555.
//  - Strobe during CLEAR:
//    - No ACK until CLEAR ends, then normal ACK.
//  - Strobe dropped in ACCESS:
//    - No DTACK; FSM returns to IDLE.

Source files
------------

// File: rtl/raizing_extratext_ram.sv
// Extra-text RAM owner: CPU write/read cycles with DTACK, zero-fill after reset, renderer read ports.
// Optional CPU read-back port: define RAIZING_EXTRATEXT_RDBACK_EN (otherwise CPU reads return 16'hFFFF).
module raizing_extratext_ram #(
  parameter int          VRAM_AW   = 12,
  parameter int          LINE_AW   = 8,
  parameter logic [15:0] CLR_VALUE = 16'h0000
) (
  input  logic               CLK96,
  input  logic               RESET96,
  input  logic [VRAM_AW-1:0] CPU_ADDR,
  input  logic [15:0]        CPU_DIN,
  output logic [15:0]        CPU_DOUT,
  input  logic               CPU_RW,
  input  logic               CPU_UDS_N,
  input  logic               CPU_LDS_N,
  input  logic               CPU_CS_VRAM,
  input  logic               CPU_CS_SELECT,
  input  logic               CPU_CS_SCROLL,
  output logic               CPU_DTACK_N,
  output logic               CLEAR_BUSY,
  input  logic [VRAM_AW-1:0] TEXTVRAM_ADDR,
  output logic [15:0]        TEXTVRAM_DATA,
  input  logic [LINE_AW-1:0] TEXTSELECT_ADDR,
  output logic [15:0]        TEXTSELECT_DATA,
  input  logic [LINE_AW-1:0] TEXTSCROLL_ADDR,
  output logic [15:0]        TEXTSCROLL_DATA
);

  // CLEAR: fill | IDLE: wait strobe | ACCESS: write / issue read | RDWAIT: capture | ACK: hold DTACK
  typedef enum logic [2:0] {S_CLEAR, S_IDLE, S_ACCESS, S_RDWAIT, S_ACK} state_t;
  typedef enum logic [1:0] {R_VRAM, R_SELECT, R_SCROLL} region_t;

  state_t  r_state, w_state_nxt;
  region_t r_region;

  logic r_uds_s1, r_uds_s2, r_lds_s1, r_lds_s2;
  logic w_strb, w_any_cs, w_start;

  logic               r_rw, r_ube, r_lbe;
  logic [VRAM_AW-1:0] r_addr;
  logic [15:0]        r_din;
  logic [VRAM_AW-1:0] r_clr_cnt;

  logic [1:0]         w_we_vram, w_we_sel, w_we_scr;
  logic [VRAM_AW-1:0] w_wa_vram;
  logic [LINE_AW-1:0] w_wa_line;
  logic [15:0]        w_wdata;
  logic               w_dout_cap;

  logic [15:0] r_vram [2**VRAM_AW];
  logic [15:0] r_sel  [2**LINE_AW];
  logic [15:0] r_scr  [2**LINE_AW];

  always_ff @(posedge CLK96 or posedge RESET96) begin
    if (RESET96) begin
      {r_uds_s1, r_uds_s2, r_lds_s1, r_lds_s2} <= 4'b1111;
    end else begin
      r_uds_s1 <= CPU_UDS_N;
      r_uds_s2 <= r_uds_s1;
      r_lds_s1 <= CPU_LDS_N;
      r_lds_s2 <= r_lds_s1;
    end
  end

  assign w_strb   = ~r_uds_s2 | ~r_lds_s2;
  assign w_any_cs = CPU_CS_VRAM | CPU_CS_SELECT | CPU_CS_SCROLL;
  assign w_start  = (r_state == S_IDLE) && w_strb && w_any_cs;

  always_ff @(posedge CLK96 or posedge RESET96) begin
    if (RESET96) r_state <= S_CLEAR;
    else         r_state <= w_state_nxt;
  end

  // Bus fields are frozen at strobe detection so a slow CPU cannot change them mid-access.
  always_ff @(posedge CLK96 or posedge RESET96) begin
    if (RESET96) begin
      r_region <= R_VRAM;
      r_rw     <= 1'b1;
      r_addr   <= '0;
      r_din    <= '0;
      r_ube    <= 1'b0;
      r_lbe    <= 1'b0;
    end else if (w_start) begin
      if (CPU_CS_VRAM)        r_region <= R_VRAM;
      else if (CPU_CS_SELECT) r_region <= R_SELECT;
      else                    r_region <= R_SCROLL;
      r_rw   <= CPU_RW;
      r_addr <= CPU_ADDR;
      r_din  <= CPU_DIN;
      r_ube  <= ~r_uds_s2;
      r_lbe  <= ~r_lds_s2;
    end
  end

  always_ff @(posedge CLK96 or posedge RESET96) begin
    if (RESET96)                 r_clr_cnt <= '0;
    else if (r_state == S_CLEAR) r_clr_cnt <= r_clr_cnt + 1'b1;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_we_vram   = 2'b00;
    w_we_sel    = 2'b00;
    w_we_scr    = 2'b00;
    w_wa_vram   = r_addr;
    w_wa_line   = r_addr[LINE_AW-1:0];
    w_wdata     = r_din;
    w_dout_cap  = 1'b0;
    case (r_state)
      S_CLEAR: begin
        w_wa_vram = r_clr_cnt;
        w_wa_line = r_clr_cnt[LINE_AW-1:0];
        w_wdata   = CLR_VALUE;
        w_we_vram = 2'b11;
        if (r_clr_cnt[VRAM_AW-1:LINE_AW] == '0) begin
          w_we_sel = 2'b11;
          w_we_scr = 2'b11;
        end
        if (r_clr_cnt == '1) w_state_nxt = S_IDLE;
      end
      S_IDLE: begin
        if (w_strb && w_any_cs) w_state_nxt = S_ACCESS;
      end
      S_ACCESS: begin
        if (!r_rw) begin
          case (r_region)
            R_VRAM:   w_we_vram = {r_ube, r_lbe};
            R_SELECT: w_we_sel  = {r_ube, r_lbe};
            R_SCROLL: w_we_scr  = {r_ube, r_lbe};
            default:  ;
          endcase
        end
        w_state_nxt = w_strb ? S_RDWAIT : S_IDLE;
      end
      S_RDWAIT: begin
        if (w_strb) begin
          w_dout_cap  = r_rw;
          w_state_nxt = S_ACK;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_ACK: begin
        if (!w_strb) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_CLEAR;
    endcase
  end

  assign CPU_DTACK_N = (r_state != S_ACK);
  assign CLEAR_BUSY  = (r_state == S_CLEAR);

  always_ff @(posedge CLK96) begin
    if (w_we_vram[1]) r_vram[w_wa_vram][15:8] <= w_wdata[15:8];
    if (w_we_vram[0]) r_vram[w_wa_vram][7:0]  <= w_wdata[7:0];
    if (w_we_sel[1])  r_sel[w_wa_line][15:8]  <= w_wdata[15:8];
    if (w_we_sel[0])  r_sel[w_wa_line][7:0]   <= w_wdata[7:0];
    if (w_we_scr[1])  r_scr[w_wa_line][15:8]  <= w_wdata[15:8];
    if (w_we_scr[0])  r_scr[w_wa_line][7:0]   <= w_wdata[7:0];
  end

  // Renderer reads sample the array before this edge's write lands, so collisions see the old word.
  always_ff @(posedge CLK96 or posedge RESET96) begin
    if (RESET96) begin
      TEXTVRAM_DATA   <= '0;
      TEXTSELECT_DATA <= '0;
      TEXTSCROLL_DATA <= '0;
    end else begin
      TEXTVRAM_DATA   <= r_vram[TEXTVRAM_ADDR];
      TEXTSELECT_DATA <= r_sel[TEXTSELECT_ADDR];
      TEXTSCROLL_DATA <= r_scr[TEXTSCROLL_ADDR];
    end
  end

`ifdef RAIZING_EXTRATEXT_RDBACK_EN
  logic [15:0] r_rb_data;
  logic        w_rd_issue;

  assign w_rd_issue = (r_state == S_ACCESS) && r_rw;

  always_ff @(posedge CLK96) begin
    if (w_rd_issue) begin
      case (r_region)
        R_VRAM:   r_rb_data <= r_vram[r_addr];
        R_SELECT: r_rb_data <= r_sel[r_addr[LINE_AW-1:0]];
        default:  r_rb_data <= r_scr[r_addr[LINE_AW-1:0]];
      endcase
    end
  end

  always_ff @(posedge CLK96 or posedge RESET96) begin
    if (RESET96)         CPU_DOUT <= '0;
    else if (w_dout_cap) CPU_DOUT <= r_rb_data;
  end
`else
  always_ff @(posedge CLK96 or posedge RESET96) begin
    if (RESET96)         CPU_DOUT <= '0;
    else if (w_dout_cap) CPU_DOUT <= 16'hFFFF;
  end
`endif

endmodule

// File: tb/tb_raizing_extratext_ram.sv
// Directed bench for raizing_extratext_ram: expected values queued at stimulus time, popped at DUT output.
module tb_raizing_extratext_ram;

  logic        CLK96, RESET96;
  logic [11:0] CPU_ADDR;
  logic [15:0] CPU_DIN, CPU_DOUT;
  logic        CPU_RW, CPU_UDS_N, CPU_LDS_N;
  logic        CPU_CS_VRAM, CPU_CS_SELECT, CPU_CS_SCROLL;
  logic        CPU_DTACK_N, CLEAR_BUSY;
  logic [11:0] TEXTVRAM_ADDR;
  logic [15:0] TEXTVRAM_DATA;
  logic [7:0]  TEXTSELECT_ADDR, TEXTSCROLL_ADDR;
  logic [15:0] TEXTSELECT_DATA, TEXTSCROLL_DATA;

  raizing_extratext_ram dut (
    .CLK96(CLK96), .RESET96(RESET96),
    .CPU_ADDR(CPU_ADDR), .CPU_DIN(CPU_DIN), .CPU_DOUT(CPU_DOUT), .CPU_RW(CPU_RW),
    .CPU_UDS_N(CPU_UDS_N), .CPU_LDS_N(CPU_LDS_N),
    .CPU_CS_VRAM(CPU_CS_VRAM), .CPU_CS_SELECT(CPU_CS_SELECT), .CPU_CS_SCROLL(CPU_CS_SCROLL),
    .CPU_DTACK_N(CPU_DTACK_N), .CLEAR_BUSY(CLEAR_BUSY),
    .TEXTVRAM_ADDR(TEXTVRAM_ADDR), .TEXTVRAM_DATA(TEXTVRAM_DATA),
    .TEXTSELECT_ADDR(TEXTSELECT_ADDR), .TEXTSELECT_DATA(TEXTSELECT_DATA),
    .TEXTSCROLL_ADDR(TEXTSCROLL_ADDR), .TEXTSCROLL_DATA(TEXTSCROLL_DATA)
  );

`ifdef RAIZING_EXTRATEXT_RDBACK_EN
  localparam logic RDBACK = 1'b1;
`else
  localparam logic RDBACK = 1'b0;
`endif

  typedef struct {string tag; logic [15:0] val;} sb_t;
  sb_t         sb_q[$];
  int          n_cmp = 0;
  int          n_mis = 0;
  logic [15:0] vq_hist[16];

  initial CLK96 = 1'b0;
  always #5 CLK96 = ~CLK96;

  task automatic push(input string tag, input logic [15:0] v);
    sb_t e;
    e.tag = tag;
    e.val = v;
    sb_q.push_back(e);
  endtask

  task automatic check_next(input logic [15:0] obs);
    sb_t e;
    n_cmp++;
    assert (sb_q.size() > 0) else begin
      n_mis++;
      $error("FAIL sb_empty: observed %h with nothing queued", obs);
    end
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      assert (obs === e.val) else begin
        n_mis++;
        $error("FAIL %s: observed %h expected %h", e.tag, obs, e.val);
      end
    end
  endtask

  task automatic rend(input logic [11:0] va, input logic [7:0] sa, input logic [7:0] ca,
                      input logic [15:0] ev, input logic [15:0] es, input logic [15:0] ec,
                      input string tag);
    @(negedge CLK96);
    TEXTVRAM_ADDR   = va;
    TEXTSELECT_ADDR = sa;
    TEXTSCROLL_ADDR = ca;
    push({tag, "_vram"}, ev);
    push({tag, "_sel"}, es);
    push({tag, "_scr"}, ec);
    @(posedge CLK96);
    #1;
    check_next(TEXTVRAM_DATA);
    check_next(TEXTSELECT_DATA);
    check_next(TEXTSCROLL_DATA);
  endtask

  task automatic cpu_cycle(input logic [2:0] cs, input logic rw, input logic [11:0] addr,
                           input logic [15:0] din, input logic [1:0] be,
                           output int lat_lo, output int lat_hi, output logic [15:0] dout);
    @(negedge CLK96);
    {CPU_CS_VRAM, CPU_CS_SELECT, CPU_CS_SCROLL} = cs;
    CPU_RW    = rw;
    CPU_ADDR  = addr;
    CPU_DIN   = din;
    CPU_UDS_N = ~be[1];
    CPU_LDS_N = ~be[0];
    lat_lo = 0;
    while (CPU_DTACK_N === 1'b1 && lat_lo < 8000) begin
      @(posedge CLK96);
      #1;
      lat_lo++;
      if (lat_lo < 16) vq_hist[lat_lo] = TEXTVRAM_DATA;
    end
    dout = CPU_DOUT;
    @(negedge CLK96);
    CPU_UDS_N = 1'b1;
    CPU_LDS_N = 1'b1;
    lat_hi = 0;
    while (CPU_DTACK_N === 1'b0 && lat_hi < 50) begin
      @(posedge CLK96);
      #1;
      lat_hi++;
    end
    @(negedge CLK96);
    {CPU_CS_VRAM, CPU_CS_SELECT, CPU_CS_SCROLL} = 3'b000;
  endtask

  initial begin
    int          lo, hi, n, k, busy_edge, low_cnt;
    logic [15:0] dout;

    RESET96 = 1'b0;
    CPU_ADDR = '0; CPU_DIN = '0; CPU_RW = 1'b1;
    CPU_UDS_N = 1'b1; CPU_LDS_N = 1'b1;
    CPU_CS_VRAM = 1'b0; CPU_CS_SELECT = 1'b0; CPU_CS_SCROLL = 1'b0;
    TEXTVRAM_ADDR = '0; TEXTSELECT_ADDR = '0; TEXTSCROLL_ADDR = '0;
    #2 RESET96 = 1'b1;
    #1;
    push("rst_dtack", 16'd1);   check_next({15'd0, CPU_DTACK_N});
    push("rst_busy", 16'd1);    check_next({15'd0, CLEAR_BUSY});
    push("rst_dout", 16'h0000); check_next(CPU_DOUT);
    push("rst_vram", 16'h0000); check_next(TEXTVRAM_DATA);
    push("rst_sel", 16'h0000);  check_next(TEXTSELECT_DATA);
    push("rst_scr", 16'h0000);  check_next(TEXTSCROLL_DATA);

    @(negedge CLK96);
    RESET96 = 1'b0;
    push("clear_cycles", 16'd4096);
    n = 0;
    while (CLEAR_BUSY === 1'b1 && n < 5000) begin
      @(posedge CLK96);
      #1;
      n++;
    end
    check_next(16'(n));

    rend(12'h000, 8'hFF, 8'hFF, 16'h0000, 16'h0000, 16'h0000, "clr_a");
    rend(12'hFFF, 8'h00, 8'h00, 16'h0000, 16'h0000, 16'h0000, "clr_b");

    // UDS-only write: upper lane only; 2 sync edges + 3 cycles to DTACK
    push("wr_lat_lo", 16'd5);
    push("wr_lat_hi", 16'd3);
    push("wr_dout_hold", 16'h0000);
    cpu_cycle(3'b100, 1'b0, 12'h123, 16'hABCD, 2'b10, lo, hi, dout);
    check_next(16'(lo));
    check_next(16'(hi));
    check_next(dout);
    rend(12'h123, 8'h00, 8'h00, 16'hAB00, 16'h0000, 16'h0000, "uds_only");

    push("scr_lat_lo", 16'd5);
    cpu_cycle(3'b001, 1'b0, 12'h105, 16'h0040, 2'b11, lo, hi, dout);
    check_next(16'(lo));
    rend(12'h000, 8'h05, 8'h05, 16'h0000, 16'h0000, 16'h0040, "scr_alias");

    cpu_cycle(3'b010, 1'b0, 12'h010, 16'h1234, 2'b11, lo, hi, dout);
    push("rd_lat_lo", 16'd5);
    push("rd_lat_hi", 16'd3);
    push("rd_dout", RDBACK ? 16'h1234 : 16'hFFFF);
    cpu_cycle(3'b010, 1'b1, 12'h010, 16'h0000, 2'b11, lo, hi, dout);
    check_next(16'(lo));
    check_next(16'(hi));
    check_next(dout);
    rend(12'h000, 8'h10, 8'h10, 16'h0000, 16'h1234, 16'h0000, "sel_wr");

    // SELECT outranks SCROLL when both are asserted
    cpu_cycle(3'b011, 1'b0, 12'h020, 16'h0BEE, 2'b11, lo, hi, dout);
    rend(12'h000, 8'h20, 8'h20, 16'h0000, 16'h0BEE, 16'h0000, "cs_prio");

    // Write lands on edge 4; renderer sampling the same address on that edge sees the old word
    @(negedge CLK96);
    TEXTVRAM_ADDR = 12'h010;
    push("coll_old", 16'h0000);
    push("coll_new", 16'h5555);
    cpu_cycle(3'b100, 1'b0, 12'h010, 16'h5555, 2'b11, lo, hi, dout);
    check_next(vq_hist[4]);
    check_next(vq_hist[5]);

    // Strobe pulse short enough to drop while the FSM is in ACCESS
    @(negedge CLK96);
    CPU_CS_VRAM = 1'b1; CPU_RW = 1'b0; CPU_ADDR = 12'h300; CPU_DIN = 16'h9999;
    CPU_UDS_N = 1'b0; CPU_LDS_N = 1'b0;
    @(posedge CLK96);
    @(negedge CLK96);
    CPU_UDS_N = 1'b1; CPU_LDS_N = 1'b1;
    low_cnt = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge CLK96);
      #1;
      if (CPU_DTACK_N !== 1'b1) low_cnt++;
    end
    push("abort_no_dtack", 16'd0);
    check_next(16'(low_cnt));
    @(negedge CLK96);
    CPU_CS_VRAM = 1'b0;
    rend(12'h300, 8'h00, 8'h00, 16'h9999, 16'h0000, 16'h0000, "abort_wr");
    push("post_abort_lat", 16'd5);
    push("post_abort_dout", RDBACK ? 16'hAB00 : 16'hFFFF);
    cpu_cycle(3'b100, 1'b1, 12'h123, 16'h0000, 2'b11, lo, hi, dout);
    check_next(16'(lo));
    check_next(dout);

    // Reset in the middle of an access, strobe held through the refill
    @(negedge CLK96);
    CPU_CS_VRAM = 1'b1; CPU_RW = 1'b0; CPU_ADDR = 12'h400; CPU_DIN = 16'h1111;
    CPU_UDS_N = 1'b0; CPU_LDS_N = 1'b0;
    repeat (3) @(posedge CLK96);
    #1;
    RESET96 = 1'b1;
    #1;
    push("midrst_dtack", 16'd1); check_next({15'd0, CPU_DTACK_N});
    push("midrst_busy", 16'd1);  check_next({15'd0, CLEAR_BUSY});
    @(negedge CLK96);
    RESET96 = 1'b0;
    push("clr_strobe_busy_edge", 16'd4096);
    push("clr_strobe_dtack_edge", 16'd4099);
    push("clr_strobe_lat_hi", 16'd3);
    k = 0;
    busy_edge = 0;
    while (CPU_DTACK_N === 1'b1 && k < 6000) begin
      @(posedge CLK96);
      #1;
      k++;
      if (CLEAR_BUSY === 1'b0 && busy_edge == 0) busy_edge = k;
    end
    check_next(16'(busy_edge));
    check_next(16'(k));
    @(negedge CLK96);
    CPU_UDS_N = 1'b1; CPU_LDS_N = 1'b1;
    hi = 0;
    while (CPU_DTACK_N === 1'b0 && hi < 50) begin
      @(posedge CLK96);
      #1;
      hi++;
    end
    check_next(16'(hi));
    @(negedge CLK96);
    CPU_CS_VRAM = 1'b0;
    rend(12'h400, 8'h10, 8'h05, 16'h1111, 16'h0000, 16'h0000, "refill_a");
    rend(12'h123, 8'h20, 8'h20, 16'h0000, 16'h0000, 16'h0000, "refill_b");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
